// File: rtl/pulse_divider_bank.sv
// Bank of CHANNELS programmable pulse_clock dividers with a valid/ready divisor port.
// Define DIVIDER_SYNC_EN to add the sync_in port that realigns all running channels.
module pulse_divider_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 16,
    parameter int RESET_DIV = 10,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                pulse_clock,
    input  logic                external_reset,
`ifdef DIVIDER_SYNC_EN
    input  logic                sync_in,
`endif
    input  logic [CHANNELS-1:0] enable,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_channel,
    input  logic [CNT_W-1:0]    cfg_divisor,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] divided_clock,
    output logic [CHANNELS-1:0] tick
);

    localparam int              PAD_W    = 1 << CH_W;
    localparam logic [CH_W:0]   CH_LIMIT = (CH_W + 1)'(CHANNELS);
    localparam logic [CNT_W-1:0] RESET_N = CNT_W'(RESET_DIV);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q  [CHANNELS];
    state_e             state_d  [CHANNELS];
    logic [CNT_W-1:0]   cnt_q    [CHANNELS];
    logic [CNT_W-1:0]   cnt_d    [CHANNELS];
    logic [CNT_W-1:0]   div_q    [CHANNELS];
    logic [CNT_W-1:0]   div_d    [CHANNELS];
    logic [CNT_W-1:0]   shadow_q [CHANNELS];
    logic [CNT_W-1:0]   shadow_d [CHANNELS];
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] dclk_q, dclk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] load_zero, apply;
    logic               cfg_err_q, cfg_err_d;
    logic [PAD_W-1:0]   pending_pad;
    logic               cfg_oob;
    logic               cfg_accept;
    logic               sync_w;

    // Divisors below 2 cannot produce a toggling output, so they are promoted to 2.
    function automatic logic [CNT_W-1:0] clamp_divisor(input logic [CNT_W-1:0] d);
        return (d < CNT_W'(2)) ? CNT_W'(2) : d;
    endfunction

`ifdef DIVIDER_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    // Padding lets non-power-of-two banks index pending with any cfg_channel value.
    assign pending_pad = PAD_W'(pending_q);
    assign cfg_oob     = ({1'b0, cfg_channel} >= CH_LIMIT);
    assign cfg_ready   = cfg_oob | ~pending_pad[cfg_channel];
    assign cfg_accept  = cfg_valid & cfg_ready;

    always_ff @(posedge pulse_clock) begin
        if (external_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
                div_q[i]   <= RESET_N;
            end
            pending_q <= '0;
            dclk_q    <= '0;
            tick_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
                div_q[i]   <= div_d[i];
            end
            pending_q <= pending_d;
            dclk_q    <= dclk_d;
            tick_q    <= tick_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Shadow contents are only meaningful while pending is set, so they carry no reset.
    always_ff @(posedge pulse_clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= shadow_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = enable[i] ? RUN : IDLE;
        end
    end

    always_comb begin
        pending_d = pending_q;
        dclk_d    = '0;
        tick_d    = '0;
        load_zero = '0;
        apply     = '0;
        cfg_err_d = cfg_accept & cfg_oob;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]    = '0;
            div_d[i]    = div_q[i];
            shadow_d[i] = shadow_q[i];

            if (state_d[i] == RUN) begin
                load_zero[i] = (state_q[i] == IDLE) || sync_w || (cnt_q[i] == div_q[i] - CNT_W'(1));
            end
            // Idle channels adopt a pending divisor immediately; running ones only at a wrap.
            apply[i] = pending_q[i] & ((state_d[i] == IDLE) | load_zero[i]);
            if (apply[i]) begin
                div_d[i]     = shadow_q[i];
                pending_d[i] = 1'b0;
            end

            if (state_d[i] == RUN) begin
                cnt_d[i]  = load_zero[i] ? '0 : cnt_q[i] + CNT_W'(1);
                tick_d[i] = load_zero[i];
                dclk_d[i] = (cnt_d[i] < (div_d[i] >> 1));
            end

            // Acceptance requires pending clear, so it never collides with an apply.
            if (cfg_accept && !cfg_oob && (cfg_channel == CH_W'(i))) begin
                shadow_d[i]  = clamp_divisor(cfg_divisor);
                pending_d[i] = 1'b1;
            end
        end
    end

    assign divided_clock = dclk_q;
    assign tick          = tick_q;
    assign cfg_err       = cfg_err_q;

endmodule
